alu_arbiter: RTL and testbench

Shares the single combinational ALU (result mux selected by 4-bit ALUControl, operands/results N+1 bits wide) between two requesters. Arbitrates requests round-robin, drives the ALU operands and ALUControl from registers, and captures result plus flags. Returns a tagged response over a valid/ready handshake. Sits between the two issuing units and the ALU in the datapath.

---
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requests are granted round-robin. The granted operands and op code are
// registered onto the ALU inputs. One cycle later the ALU result and flags
// are captured, and they are returned to the owner over a valid/ready
// response handshake. The block only steers and registers data; the ALU
// itself sits outside.
module alu_arbiter #(
  parameter int N = 4  // MSB index of operands/results
) (
  input  logic         clk,
  input  logic         rst,         // asynchronous, active-low
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N:0]   req0_a,
  input  logic [N:0]   req0_b,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N:0]   req1_a,
  input  logic [N:0]   req1_b,
  // shared ALU
  output logic [N:0]   alu_a,
  output logic [N:0]   alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N:0]   alu_q,
  input  logic [3:0]   alu_flags,   // {N,Z,C,V}
  // response
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N:0]   rsp_q,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err
);

  // Highest op code the ALU mux decodes; anything above falls to input 0.
  localparam logic [3:0] OP_LAST_LEGAL = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a request; grant is combinational
    EXEC = 2'd1,  // ALU inputs registered, ALU output settling
    RESP = 2'd2   // response held until the consumer takes it
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       last;      // requester granted most recently
  logic       grant;     // requester chosen this cycle (valid only in IDLE)
  logic       accept;    // an operation is taken at the coming edge
  logic [3:0] sel_op;
  logic [N:0] sel_a;
  logic [N:0] sel_b;

  // Round-robin choice: a lone requester always wins. On a tie the one
  // that was not served last wins, so both requesters alternate strictly.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Operand steering from the granted requester.
  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (grant) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // flop samples values from before the edge, independent of order.
      state <= state_nxt;
    end
  end

  // Next-state logic and the accept handshake.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ALU input registers. They are loaded only on accept and hold otherwise.
  // The owner, the round-robin pointer and the error flag are set here too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 4'b0000;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
      last     <= 1'b1;   // requester 0 wins the first tie
    end else if (accept) begin
      alu_a    <= sel_a;
      alu_b    <= sel_b;
      alu_ctrl <= sel_op;
      rsp_id   <= grant;
      rsp_err  <= (sel_op > OP_LAST_LEGAL);
      last     <= grant;
    end
  end

  // Result capture at the end of EXEC. The response is then held stable
  // until rsp_ready is seen in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_q     <= '0;
      rsp_flags <= 4'b0000;
      rsp_valid <= 1'b0;
    end else begin
      if (state == EXEC) begin
        rsp_q     <= alu_q;
        rsp_flags <= alu_flags;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed test of the round-robin ALU arbiter.
// A small combinational ALU stands in for the real datapath ALU. Its
// encoding is 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor. Any other
// code behaves as add, which is input 0 of the ALU mux.
module tb_alu_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         req0_valid;
  logic         req0_ready;
  logic [3:0]   req0_op;
  logic [N:0]   req0_a;
  logic [N:0]   req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [3:0]   req1_op;
  logic [N:0]   req1_a;
  logic [N:0]   req1_b;
  logic [N:0]   alu_a;
  logic [N:0]   alu_b;
  logic [3:0]   alu_ctrl;
  logic [N:0]   alu_q;
  logic [3:0]   alu_flags;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N:0]   rsp_q;
  logic [3:0]   rsp_flags;
  logic         rsp_err;

  int total;
  int bad;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_q      (alu_q),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_q      (rsp_q),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU. Carry and overflow come from the add/sub path only.
  logic [N+1:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    alu_q   = '0;
    unique case (alu_ctrl)
      4'b0001: begin
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
        alu_q   = alu_sum[N:0];
      end
      4'b0010: alu_q = alu_a & alu_b;
      4'b0011: alu_q = alu_a | alu_b;
      4'b0100: alu_q = alu_a ^ alu_b;
      default: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_q   = alu_sum[N:0];
      end
    endcase
    alu_flags[3] = alu_q[N];
    alu_flags[2] = (alu_q == '0);
    alu_flags[1] = alu_sum[N+1];
    alu_flags[0] = (alu_ctrl inside {4'b0010, 4'b0011, 4'b0100}) ? 1'b0 :
                   ((alu_a[N] == alu_b[N]) && (alu_q[N] != alu_a[N]));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_readies", 32'({req0_ready, req1_ready}), 32'h0);
    rst = 1'b1;
    step();

    // Single req0 add 3+4
    req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 5'h03; req0_b = 5'h04;
    #1;
    check("t1_req0_ready", 32'(req0_ready), 32'h1);
    check("t1_req1_ready", 32'(req1_ready), 32'h0);
    step();                                   // EXEC
    req0_valid = 1'b0;
    #1;
    check("t1_ready_1cyc", 32'(req0_ready), 32'h0);
    check("t1_alu_ctrl", 32'(alu_ctrl), 32'h0);
    check("t1_alu_ab", 32'({alu_a, alu_b}), 32'({5'h03, 5'h04}));
    check("t1_exec_novalid", 32'(rsp_valid), 32'h0);
    step();                                   // RESP
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_q", 32'(rsp_q), 32'h07);
    check("t1_rsp_id", 32'(rsp_id), 32'h0);
    check("t1_rsp_err", 32'(rsp_err), 32'h0);
    check("t1_rsp_flags", 32'(rsp_flags), 32'h0);
    step();                                   // IDLE
    check("t1_rsp_clear", 32'(rsp_valid), 32'h0);

    // req1 alone: 1F + 01 wraps to zero, flags {N,Z,C,V} = 0110
    req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 5'h1F; req1_b = 5'h01;
    #1;
    check("t2_req1_ready", 32'(req1_ready), 32'h1);
    step();
    req1_valid = 1'b0;
    step();
    check("t2_rsp_q", 32'(rsp_q), 32'h00);
    check("t2_rsp_flags", 32'(rsp_flags), 32'h6);
    check("t2_rsp_id", 32'(rsp_id), 32'h1);
    step();

    // Both valid continuously: grants 0,1,0,1, one response every 3 cycles
    req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 5'h02; req0_b = 5'h03;  // 05
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 5'h1C; req1_b = 5'h0A;  // 08
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr%0d_ready", k), 32'({req0_ready, req1_ready}),
            (k % 2 == 0) ? 32'h2 : 32'h1);
      step();
      check($sformatf("rr%0d_exec", k), 32'(rsp_valid), 32'h0);
      step();
      check($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(k % 2));
      check($sformatf("rr%0d_q", k), 32'(rsp_q), (k % 2 == 0) ? 32'h05 : 32'h08);
      check($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'h1);
      step();
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Illegal op from req1 executes as op 0000 and is flagged
    req1_valid = 1'b1; req1_op = 4'b1100; req1_a = 5'h03; req1_b = 5'h04;
    #1;
    check("ill_ready", 32'(req1_ready), 32'h1);
    step();
    req1_valid = 1'b0;
    step();
    check("ill_rsp_q", 32'(rsp_q), 32'h07);
    check("ill_rsp_err", 32'(rsp_err), 32'h1);
    check("ill_rsp_id", 32'(rsp_id), 32'h1);
    step();

    // Backpressure: rsp_ready low 5 cycles, req0 pulse during RESP ignored
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0011; req0_a = 5'h05; req0_b = 5'h0A;  // 0F
    #1;
    check("bp_accept", 32'(req0_ready), 32'h1);
    step();
    req0_valid = 1'b0;
    req0_op = 4'b0000; req0_a = 5'h11; req0_b = 5'h11;
    step();                                   // RESP, first held cycle
    for (int k = 0; k < 5; k++) begin
      req0_valid = (k == 1);
      #1;
      check($sformatf("bp%0d_hold", k), 32'({rsp_valid, rsp_id, rsp_q}),
            32'({1'b1, 1'b0, 5'h0F}));
      check($sformatf("bp%0d_readies", k), 32'({req0_ready, req1_ready}), 32'h0);
      step();
    end
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    req1_valid = 1'b1; req1_op = 4'b0100; req1_a = 5'h15; req1_b = 5'h0F;  // 1A
    step();                                   // IDLE, one cycle after rsp_ready
    check("bp_done", 32'(rsp_valid), 32'h0);
    check("bp_next_ready", 32'({req0_ready, req1_ready}), 32'h1);
    step();
    req1_valid = 1'b0;
    step();
    check("bp_next_rsp", 32'({rsp_id, rsp_q}), 32'({1'b1, 5'h1A}));
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("no_stale%0d", k), 32'(rsp_valid), 32'h0);
    end

    // Asynchronous reset in the middle of EXEC
    req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 5'h01; req1_b = 5'h01;
    step();                                   // EXEC
    req1_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_ctrl", 32'(alu_ctrl), 32'h0);
    check("mid_rst_ab", 32'({alu_a, alu_b}), 32'h0);
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    #1;
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 5'h08; req0_b = 5'h09;  // 11
    req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 5'h01; req1_b = 5'h01;
    #1;
    check("post_rst_tie", 32'({req0_ready, req1_ready}), 32'h2);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("post_rst_exec", 32'(rsp_valid), 32'h0);
    step();
    check("post_rst_rsp", 32'({rsp_valid, rsp_id, rsp_q}), 32'({1'b1, 1'b0, 5'h11}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
